rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL use a single clock domain and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  4  per-requester request, index 0..3.
REQ-005 din  input  4  per-requester data bit; din[i] belongs to requester i.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 sel  output  2  registered mux select equal to the owner index; sel[1]=s1, sel[0]=s0 encoding.
REQ-008 y  output  1  shared output, equal to din[sel] while busy, else 0.
REQ-009 busy  output  1  registered; 1 while in GRANT state.
REQ-010 Parameter MAX_HOLD, default 8, range 2..15, is the maximum number of consecutive grant cycles per ownership.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 Rotating pointer ptr[1:0] SHALL hold the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE, req==0: the block SHALL stay in IDLE with gnt=0, busy=0 and sel unchanged.
REQ-014 IDLE, req!=0: at the next edge the block SHALL enter GRANT with gnt one-hot on the first requesting index in search order; latency is 1 cycle from req sampled to gnt visible.
REQ-015 GRANT: gnt, sel and the owner index SHALL remain constant; requests from other indices SHALL be ignored.
REQ-016 The hold counter SHALL load 1 on entry to GRANT and increment each further GRANT cycle; its width is 4 bits.
REQ-017 Release SHALL occur at the edge where req[owner]==0 is sampled, or where the counter equals MAX_HOLD, whichever comes first.
REQ-018 On release: next state IDLE, gnt=0, busy=0, ptr=owner+1 mod 4 (3 wraps to 0).
REQ-019 After each release the block SHALL spend at least one IDLE cycle, with no direct handoff between owners.
REQ-020 A requester still asserting req at timeout SHALL lose the grant and SHALL be re-granted only via the normal rotation; if it is the sole requester, it is re-granted after one IDLE cycle.
REQ-021 If req[owner] drops and the counter reaches MAX_HOLD on the same edge, the block SHALL perform a single release with identical effect.
REQ-022 y SHALL be combinational from din and registered sel, gated by busy; there is no data latency beyond the select.

Reset
REQ-023 While rst_n==0: state=IDLE, gnt=0, sel=0, busy=0, ptr=0, counter=0, which forces y=0.
REQ-024 Asserting reset mid-GRANT SHALL drop the grant immediately, asynchronously, without waiting for a clock.
REQ-025 The first arbitration after reset release SHALL start from ptr=0.

Structure
REQ-026 State encodings, the default MAX_HOLD and the requester count (4) SHALL live in a shared include file used by this block and its bench.
REQ-027 The 4:1 data select SHALL be a separate sub-module, mux4_sel (inputs d[3:0], s[1:0]; output y); gating by busy stays in rr_mux_arbiter.
REQ-028 Grant selection SHALL be a single priority-rotate function; no per-requester FSMs.

Verification
REQ-029 Reset, then req=4'b0101 held high -> gnt=0001 after 1 cycle, timeout after 8 cycles, 1 IDLE cycle, then gnt=0100.
REQ-030 After owner 3 releases, req=4'b1001 -> ptr wraps to 0 and gnt=0001.
REQ-031 Owner 2 with din=4'b0100 -> y=1; din[2] toggled each cycle -> y follows in the same cycle; other din bits ignored.
REQ-032 Only req[1] held continuously -> grant pattern of 8 cycles on, 1 cycle off, repeating; busy matches.
REQ-033 rst_n pulsed low during GRANT cycle 3 -> gnt=0, y=0 without a clock; after release, req=4'b1000 -> gnt=1000 after 1 cycle.
REQ-034 Owner drops req at hold count 8 -> exactly one release and ptr advanced once; check that gnt is never more than one-hot (assertion).

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and the rotating-priority grant picker
// used by rr_mux_arbiter and its bench.
package rr_mux_arbiter_pkg;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First requesting index in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] result;
        logic             found;
        result = ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4_sel.sv
// Plain 4:1 single-bit data select driven by the arbiter's registered owner index.
module mux4_sel
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] d,
    input  logic [IDX_W-1:0]   s,
    output logic               y
);

    always_comb begin
        y = 1'b0;
        case (s)
            2'd0:    y = d[0];
            2'd1:    y = d[1];
            2'd2:    y = d[2];
            default: y = d[3];
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time, steering the
// owner's data bit onto a shared output.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  din,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]    sel,
    output logic                y,
    output logic                busy
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] pick;
    logic             release_now;
    logic             mux_y;

    assign pick        = rr_pick(req, ptr);
    assign release_now = !req[sel] || (cnt == CNT_W'(MAX_HOLD));

    // Owner, grant and busy are all registered; sel doubles as the owner index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        state <= ST_GRANT;
                        gnt   <= NUM_REQ'(1) << pick;
                        sel   <= pick;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    // Drop and timeout on the same edge collapse into one release.
                    if (release_now) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= sel + IDX_W'(1);
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mux4_sel u_mux (
        .d (din),
        .s (sel),
        .y (mux_y)
    );

    assign y = busy & mux_y;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: hand-computed grant sequences, timeout,
// pointer wrap, data steering and asynchronous reset.
module tb_rr_mux_arbiter;
    import rr_mux_arbiter_pkg::*;

    logic                clk;
    logic                rst_n;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  din;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    sel;
    logic                y;
    logic                busy;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and confirm grant is at most one-hot.
    task automatic step();
        @(posedge clk);
        #1;
        total++;
        assert ($onehot0(gnt)) else begin
            bad++;
            $error("FAIL onehot: observed=%b expected=at most one bit set", gnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        step();
        step();
        check("rst_gnt",  gnt, 4'b0000);
        check("rst_sel",  4'(sel), 4'd0);
        check("rst_busy", 4'(busy), 4'd0);
        check("rst_y",    4'(y), 4'd0);
        rst_n = 1'b1;

        // 0101 held: owner 0 for 8 cycles, one idle cycle, then owner 2.
        req = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("hold0_c%0d", k), gnt, 4'b0001);
        end
        check("hold0_busy", 4'(busy), 4'd1);
        step();
        check("timeout_gnt",  gnt, 4'b0000);
        check("timeout_busy", 4'(busy), 4'd0);
        step();
        check("rot_gnt2", gnt, 4'b0100);
        check("rot_sel2", 4'(sel), 4'd2);

        // Data steering from owner 2, same cycle, other bits ignored.
        din = 4'b0100; #1;
        check("y_d0100", 4'(y), 4'd1);
        din = 4'b1011; #1;
        check("y_d1011", 4'(y), 4'd0);
        din = 4'b1111; #1;
        check("y_d1111", 4'(y), 4'd1);
        din = 4'b0000; #1;
        check("y_d0000", 4'(y), 4'd0);
        din = 4'b0100; #1;
        check("y_d0100b", 4'(y), 4'd1);

        // Owner 2 drops: release, ptr -> 3.
        req = 4'b0000;
        step();
        check("drop2_gnt", gnt, 4'b0000);
        check("drop2_y",   4'(y), 4'd0);
        step();
        check("idle_gnt", gnt, 4'b0000);
        check("idle_sel", 4'(sel), 4'd2);

        // Owner 3, then pointer wraps to 0.
        req = 4'b1000;
        step();
        check("own3_gnt", gnt, 4'b1000);
        req = 4'b0000;
        step();
        check("rel3_gnt", gnt, 4'b0000);
        req = 4'b1001;
        step();
        check("wrap_gnt", gnt, 4'b0001);
        check("wrap_sel", 4'(sel), 4'd0);
        req = 4'b0000;
        step();
        check("rel0_gnt", gnt, 4'b0000);

        // Sole requester 1: 8 on, 1 off, repeating.
        req = 4'b0010;
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= 8; k++) begin
                step();
                check($sformatf("solo_p%0d_c%0d_gnt", p, k), gnt, 4'b0010);
                check($sformatf("solo_p%0d_c%0d_busy", p, k), 4'(busy), 4'd1);
            end
            step();
            check($sformatf("solo_p%0d_off_gnt", p), gnt, 4'b0000);
            check($sformatf("solo_p%0d_off_busy", p), 4'(busy), 4'd0);
        end
        req = 4'b0000;
        step();

        // Async reset in GRANT cycle 3 of owner 2.
        req = 4'b0100;
        din = 4'b0100;
        step();
        step();
        step();
        check("pre_rst_gnt", gnt, 4'b0100);
        check("pre_rst_y",   4'(y), 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt",  gnt, 4'b0000);
        check("async_y",    4'(y), 4'd0);
        check("async_busy", 4'(busy), 4'd0);
        step();
        rst_n = 1'b1;
        req = 4'b1000;
        step();
        check("post_rst_gnt", gnt, 4'b1000);
        req = 4'b0000;
        step();
        check("post_rst_rel", gnt, 4'b0000);

        // Drop coincides with count 8: single release, ptr 0 -> 1 only.
        req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("coinc_c%0d", k), gnt, 4'b0001);
        end
        req = 4'b0110;
        step();
        check("coinc_rel_gnt",  gnt, 4'b0000);
        check("coinc_rel_busy", 4'(busy), 4'd0);
        step();
        check("coinc_next_gnt", gnt, 4'b0010);
        check("coinc_next_sel", 4'(sel), 4'd1);
        req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
